// File: rtl/cpu_cluster_pkg.sv
// Shared types and defaults for the multi-CPU cluster.
//   N_CPUS_DEF/ADDR_W_DEF/DATA_W_DEF : default cluster geometry
//   STALL_W                          : width of per-CPU stall counters
//   word_t                           : one instruction word
//   idx_w()                          : index width for N items (at least 1 bit)
//   cpu_idx_t                        : CPU index for the default cluster size
package cpu_cluster_pkg;
  localparam int N_CPUS_DEF = 3;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STALL_W    = 16;

  typedef logic [31:0] word_t;

  // $clog2(1) is 0, which cannot size a vector
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_w(N_CPUS_DEF)-1:0] cpu_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index that has highest priority this cycle (0..N-1)
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : index of the granted requester (0 when none)
module rr_arbiter
  import cpu_cluster_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [idx_w(N)-1:0] gnt_idx
);
  localparam int IW = idx_w(N);

  int   pos;
  logic found;

  // Walk from ptr upward, wrapping at N (not at 2**IW).
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = pos[IW-1:0];
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/shared_imem_arbiter.sv
// Shares one single-port, 1-cycle-latency instruction ROM between N CPUs.
//   req_valid/req_addr : per-CPU fetch requests (byte PC)
//   req_ready          : combinational one-hot grant
//   rsp_valid/rsp_data : per-CPU response, one cycle after the grant;
//                        rsp_data holds its value between responses
//   mem_rd/mem_addr    : ROM read port (word address)
//   mem_rdata          : ROM data, valid the cycle after mem_rd
//   stall_cnt          : saturating per-CPU stall counters, present only
//                        when SHARED_IMEM_ARB_STATS_EN is defined
module shared_imem_arbiter
  import cpu_cluster_pkg::*;
#(
  parameter int N_CPUS = N_CPUS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_AW = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CPUS-1:0]              req_valid,
  input  logic [N_CPUS-1:0][ADDR_W-1:0]  req_addr,
  output logic [N_CPUS-1:0]              req_ready,
  output logic [N_CPUS-1:0]              rsp_valid,
  output logic [N_CPUS-1:0][DATA_W-1:0]  rsp_data,
  output logic                           mem_rd,
  output logic [MEM_AW-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_rdata
`ifdef SHARED_IMEM_ARB_STATS_EN
  ,
  output logic [N_CPUS-1:0][STALL_W-1:0] stall_cnt
`endif
);
  localparam int IW = idx_w(N_CPUS);

  logic [N_CPUS-1:0]             gnt;
  logic [IW-1:0]                 gnt_idx;
  logic                          grant;
  logic [IW-1:0]                 rr_ptr;
  logic                          pend_vld;
  logic [IW-1:0]                 pend_id;
  logic [N_CPUS-1:0][DATA_W-1:0] data_q;
  logic                          unused_addr_bits;

  rr_arbiter #(.N(N_CPUS)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Nothing is granted while reset is held.
  assign grant     = rst_n & (|gnt);
  assign req_ready = grant ? gnt : '0;
  assign mem_rd    = grant;
  assign mem_addr  = grant ? req_addr[gnt_idx][MEM_AW+1:2] : '0;

  // Byte-offset and out-of-range PC bits are deliberately dropped (aliasing).
  assign unused_addr_bits = ^req_addr;

  // The ROM data arrives in the cycle after the grant, so the pending lane
  // shows mem_rdata directly; data_q keeps it for the hold requirement.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = data_q;
    if (pend_vld) begin
      rsp_valid[pend_id] = 1'b1;
      rsp_data[pend_id]  = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      pend_vld <= 1'b0;
      pend_id  <= '0;
      data_q   <= '0;
    end else begin
      pend_vld <= grant;
      pend_id  <= gnt_idx;
      if (grant)
        rr_ptr <= (gnt_idx == IW'(N_CPUS-1)) ? '0 : gnt_idx + IW'(1);
      if (pend_vld)
        data_q[pend_id] <= mem_rdata;
    end
  end

`ifdef SHARED_IMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CPUS; i++)
        if (req_valid[i] && !req_ready[i] && stall_cnt[i] != '1)
          stall_cnt[i] <= stall_cnt[i] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_shared_imem_arbiter.sv
module tb_shared_imem_arbiter;
  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0][31:0] rsp_data;
  logic              mem_rd;
  logic [5:0]        mem_addr;
  logic [31:0]       mem_rdata = '0;
`ifdef SHARED_IMEM_ARB_STATS_EN
  logic [N-1:0][15:0] stall_cnt;
`endif

  shared_imem_arbiter #(.N_CPUS(N), .ADDR_W(32), .DATA_W(32), .MEM_AW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
`ifdef SHARED_IMEM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM with 1-cycle read latency
  logic [31:0] rom [64];
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE0000 + i * 32'h00010003;
    rom[12] = 32'h00500513;
  end
  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // Priority rotates: the requester after the last winner goes first.
  // A win makes that CPU's ROM word its visible response next cycle.
  int          m_ptr = 0;
  logic [N-1:0] m_rsp_vld = '0;
  logic [31:0] m_rsp_data [N] = '{default: '0};
  int          m_stall [N] = '{default: 0};

  function automatic int m_grant();
    if (rst_n !== 1'b1) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr     <= 0;
      m_rsp_vld <= '0;
      for (int i = 0; i < N; i++) begin
        m_rsp_data[i] <= '0;
        m_stall[i]    <= 0;
      end
    end else begin
      m_rsp_vld <= '0;
      if (m_grant() >= 0) begin
        m_rsp_vld[m_grant()]  <= 1'b1;
        m_rsp_data[m_grant()] <= rom[(req_addr[m_grant()] >> 2) % 64];
        m_ptr <= (m_grant() + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && m_grant() != i && m_stall[i] < 65535) m_stall[i] <= m_stall[i] + 1;
    end
  end

  // Per-cycle comparison against the model
  int cmp_g;
  logic [N-1:0][31:0] cmp_data;
  always @(negedge clk) begin
    cmp_g = m_grant();
    for (int i = 0; i < N; i++) cmp_data[i] = m_rsp_data[i];
    chk("req_ready", 128'(req_ready), (cmp_g >= 0) ? 128'(1) << cmp_g : 128'(0));
    chk("mem_rd",    128'(mem_rd),    128'(cmp_g >= 0));
    chk("mem_addr",  128'(mem_addr),  (cmp_g >= 0) ? 128'((req_addr[cmp_g] >> 2) % 64) : 128'(0));
    chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_vld));
    chk("rsp_data",  128'(rsp_data),  128'(cmp_data));
`ifdef SHARED_IMEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stall_cnt", 128'(stall_cnt[i]), 128'(m_stall[i]));
`endif
  end

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cyc();  // advance to just after the next rising edge
    @(posedge clk); #1;
  endtask
  task automatic smp();  // just after the sampling edge
    @(negedge clk); #1;
  endtask

  int exp_order [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int got_order [9];
  int rsp_cnt [N];
  int cnt1;
  logic [2:0]  pat_v [6] = '{3'b111, 3'b011, 3'b000, 3'b110, 3'b101, 3'b001};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset then idle
    smp(); smp();
    chk("idle_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("idle_mem_rd",    128'(mem_rd), 128'(0));
    chk("idle_rsp_data",  128'(rsp_data), 128'(0));
    chk("idle_rr_ptr",    128'(dut.rr_ptr), 128'(0));

    // single CPU1 fetch
    cyc(); req_valid = 3'b010; req_addr[1] = 32'h30;
    smp();
    chk("single_ready", 128'(req_ready), 128'(3'b010));
    chk("single_maddr", 128'(mem_addr), 128'(12));
    cyc(); req_valid = '0;
    smp();
    chk("single_rsp_valid", 128'(rsp_valid), 128'(3'b010));
    chk("single_rsp_data",  128'(rsp_data[1]), 128'(32'h00500513));
    smp();
    chk("single_hold_data", 128'(rsp_data[1]), 128'(32'h00500513));
    chk("single_one_shot",  128'(rsp_valid), 128'(0));

    // fresh reset, then all three request for 9 cycles
    cyc(); rst_n = 1'b0;
    cyc(); cyc(); rst_n = 1'b1;
    cyc(); req_valid = 3'b111;
    req_addr[0] = 32'h40; req_addr[1] = 32'h44; req_addr[2] = 32'h48;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    for (int k = 0; k < 9; k++) begin
      smp();
      got_order[k] = oh2i(req_ready);
      for (int i = 0; i < N; i++) rsp_cnt[i] += int'(rsp_valid[i]);
    end
    cyc(); req_valid = '0;
    smp();
    for (int i = 0; i < N; i++) rsp_cnt[i] += int'(rsp_valid[i]);
    for (int k = 0; k < 9; k++) chk("rr_order", 128'(got_order[k]), 128'(exp_order[k]));
    for (int i = 0; i < N; i++) chk("rr_rsp_count", 128'(rsp_cnt[i]), 128'(3));
`ifdef SHARED_IMEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stall_6", 128'(stall_cnt[i]), 128'(6));
`endif

    // pointer wrap: CPU2 granted, then CPU0 wins over CPU2
    cyc(); req_valid = 3'b100;
    smp(); chk("wrap_g2", 128'(req_ready), 128'(3'b100));
    cyc(); req_valid = 3'b101;
    smp(); chk("wrap_g0", 128'(req_ready), 128'(3'b001));
    cyc();
    smp(); chk("wrap_g2b", 128'(req_ready), 128'(3'b100));

    // aliasing and address change while stalled
    cyc(); req_valid = 3'b011; req_addr[0] = 32'h0; req_addr[1] = 32'hFFFFFF33;
    smp(); chk("alias_g0", 128'(req_ready), 128'(3'b001));
    chk("alias_maddr0", 128'(mem_addr), 128'(0));
    cyc(); req_valid = 3'b010; req_addr[1] = 32'h12345674;
    smp(); chk("stall_addr", 128'(mem_addr), 128'(29));
    cyc(); req_valid = '0;
    smp(); chk("stall_data", 128'(rsp_data[1]), 128'(rom[29]));

    // CPU1 drops its request before winning: no response for it
    cyc(); req_valid = 3'b110;
    smp(); chk("drop_g2", 128'(req_ready), 128'(3'b100));
    cyc(); req_valid = 3'b100;
    cnt1 = 0;
    repeat (3) begin smp(); cnt1 += int'(rsp_valid[1]); end
    chk("drop_no_rsp", 128'(cnt1), 128'(0));
    cyc(); req_valid = '0;

    // reset while a response is pending
    cyc(); req_valid = 3'b001;
    smp(); chk("mid_g0", 128'(req_ready), 128'(3'b001));
    rst_n = 1'b0; req_valid = '0;
    smp(); chk("mid_rst_ready", 128'(req_ready), 128'(0));
    chk("mid_rst_rsp", 128'(rsp_valid), 128'(0));
    cyc(); rst_n = 1'b1;
    cnt1 = 0;
    repeat (2) begin smp(); cnt1 += int'(|rsp_valid); end
    chk("mid_no_rsp", 128'(cnt1), 128'(0));
    cyc(); req_valid = 3'b111;
    smp(); chk("mid_first_g0", 128'(req_ready), 128'(3'b001));

    // mixed request patterns, checked by the model each cycle
    for (int p = 0; p < 6; p++) begin
      cyc(); req_valid = pat_v[p];
      for (int i = 0; i < N; i++) req_addr[i] = 32'h100 * (p + 1) + 32'(i * 4 + p);
    end
    cyc(); req_valid = '0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shared_imem_arbiter.md
Name: shared_imem_arbiter

Overview:
- Responder side of the instruction-fetch interface in the multi-CPU cluster.
- N CPUs issue fetch requests (valid/addr). One single-port synchronous instruction ROM (1-cycle read latency) is shared between them through round-robin arbitration.
- Each CPU gets its instruction word back one cycle after its grant. Non-granted CPUs see req_ready low and stall.

Parameters:
- N_CPUS, 3, number of requesting CPUs (>= 1).
- ADDR_W, 32, CPU byte-address width.
- DATA_W, 32, instruction word width.
- MEM_AW, 6, ROM word-address width. ROM depth is 2**MEM_AW words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_CPUS  per-CPU fetch request.
- req_addr  in  N_CPUS x ADDR_W  per-CPU byte address (PC).
- req_ready  out  N_CPUS  per-CPU grant. Combinational, at most one bit high.
- rsp_valid  out  N_CPUS  per-CPU response strobe. Registered.
- rsp_data  out  N_CPUS x DATA_W  per-CPU instruction word. Holds its value between responses.
- mem_rd  out  1  ROM read enable.
- mem_addr  out  MEM_AW  ROM word address = req_addr[g][MEM_AW+1:2] of the granted CPU g.
- mem_rdata  in  DATA_W  ROM data, valid the cycle after mem_rd.

Behaviour:
- Reset (rst_n low, async), all registers cleared:
  - rr_ptr = 0
  - rsp_valid = 0
  - all rsp_data = 0
  - pending-grant register (pend_vld = 0, pend_id = 0)
- Reset outputs: mem_rd = 0 and req_ready = 0 while rst_n is low.
- Arbitration (combinational, every cycle):
  - Search req_valid starting at index rr_ptr and wrap modulo N_CPUS. The first set bit is grant g.
  - req_ready[g] = 1, mem_rd = 1, mem_addr = word address of req_addr[g].
  - A handshake on CPU i is req_valid[i] and req_ready[i].
- No request present: req_ready = 0, mem_rd = 0, mem_addr = 0, rr_ptr unchanged.
- Pointer update: on a grant, rr_ptr <= (g == N_CPUS-1) ? 0 : g+1. There is no binary wrap past N_CPUS.
- Response (latency exactly 1 cycle after the handshake):
  - pend_vld <= grant, pend_id <= g.
  - Next cycle: rsp_valid[pend_id] = 1 for one cycle and rsp_data[pend_id] <= mem_rdata.
  - The other rsp_data entries keep their value.
- Throughput: one grant per cycle. A new grant in the same cycle as the previous response is allowed, so the pipeline is full.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,N-1,0,... Each CPU waits at most N-1 cycles.
- Boundaries:
  - N_CPUS = 1: always grant 0, rr_ptr stays 0.
  - Address bits [1:0] and bits above MEM_AW+1 are ignored. Out-of-range addresses alias.
  - A request dropped before its grant is legal and produces no response.
  - A CPU changing addr while stalled: the addr present in the grant cycle is used.
  - Reset asserted mid-flight: the pending response is discarded. No rsp_valid after reset release until a new grant.

Optional Feature:
- Macro: SHARED_IMEM_ARB_STATS_EN.
- Defined:
  - Extra output port stall_cnt (N_CPUS x 16) is present.
  - Per CPU, the count increments on cycles with req_valid[i] = 1 and req_ready[i] = 0.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: the port and counters are absent. Functional behaviour is identical.

Decomposition:
- Package cpu_cluster_pkg:
  - constants: default N_CPUS = 3, ADDR_W = 32, DATA_W = 32
  - typedef word_t = logic [31:0]
  - typedef for the CPU index (clog2 of N_CPUS)
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req and ptr. Outputs: onehot grant and grant index.
  - Purely combinational. It is reused elsewhere in the cluster.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then no requests. rsp_valid = 0, mem_rd = 0, rsp_data all 0, rr_ptr = 0.
- Single CPU:
  - CPU1 requests addr 32'h30 with ROM[12] = 32'h00500513.
  - req_ready[1] = 1 and mem_addr = 12 in the same cycle.
  - Next cycle rsp_valid = 3'b010 and rsp_data[1] = 32'h00500513.
- All three request continuously for 9 cycles:
  - Grant order is 0,1,2,0,1,2,0,1,2.
  - Each CPU gets 3 responses, each exactly 1 cycle after its grant.
  - With the macro enabled, stall_cnt = 6 for each CPU.
- Pointer wrap:
  - CPU2 is granted.
  - Next cycle CPU0 and CPU2 both request: CPU0 is granted first (rr_ptr = 0). CPU2 is granted the following cycle.
- Reset mid-flight:
  - Grant CPU0, then pull rst_n low before the response edge.
  - No rsp_valid appears. After release, the first grant goes to CPU0.
- Cluster smoke test:
  - Three CPUs, PCs 0, 0, 32'h30.
  - a0 reaches 32'h00213d05 on CPUs 0 and 1 and 32'h1c8cfc00 on CPU 2 within 1000 cycles.
